// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO registers.
// Multiplies use radix-2 shift-add and divides use restoring division, one bit per cycle.
// Signed operands are reduced to magnitudes and the signs are restored in FIX.
// Optional feature macro: MULDIV_EARLY_OUT_EN. When it is defined, a multiply leaves RUN
// as soon as the remaining multiplier bits are all zero.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               isDiv_q;
    logic               negRes_q;
    logic               negRem_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               divZero_q;
    logic               quick_q;
    logic               quickZero_q;

    logic               signedOp_d;
    logic               aNeg_d;
    logic               bNeg_d;
    logic [WIDTH-1:0]   aMag_d;
    logic [WIDTH-1:0]   bMag_d;
    logic [2*WIDTH-1:0] mulAcc_d;
    logic [WIDTH:0]     remShift_d;
    logic [WIDTH:0]     remDiff_d;
    logic [WIDTH:0]     remNext_d;
    logic               qBit_d;
    logic               lastIter_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   rem_d;

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = divZero_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

    // Operand magnitudes and sign flags captured when a signed operation is issued.
    always_comb begin
        signedOp_d = (op == OP_MULT) || (op == OP_DIV);
        aNeg_d     = signedOp_d & A[WIDTH-1];
        bNeg_d     = signedOp_d & B[WIDTH-1];
        aMag_d     = aNeg_d ? -A : A;
        bMag_d     = bNeg_d ? -B : B;
    end

    // One iteration of shift-add or restoring divide, plus the sign-corrected results for FIX.
    always_comb begin
        mulAcc_d   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        remShift_d = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
        remDiff_d  = remShift_d - {1'b0, mcand_q[WIDTH-1:0]};
        qBit_d     = ~remDiff_d[WIDTH];
        remNext_d  = qBit_d ? remDiff_d : remShift_d;
        lastIter_d = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
        if (!isDiv_q && (mplier_q[WIDTH-1:1] == '0)) begin
            lastIter_d = 1'b1;
        end
`endif
        prod_d = negRes_q ? -acc_q : acc_q;
        quo_d  = negRes_q ? -mplier_q : mplier_q;
        rem_d  = negRem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end

    // Control FSM and datapath registers; single-cycle ops report done one edge after their write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            isDiv_q     <= 1'b0;
            negRes_q    <= 1'b0;
            negRem_q    <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            divZero_q   <= 1'b0;
            quick_q     <= 1'b0;
            quickZero_q <= 1'b0;
        end else begin
            done_q      <= quick_q;
            divZero_q   <= quickZero_q;
            quick_q     <= 1'b0;
            quickZero_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                isDiv_q  <= 1'b0;
                                negRes_q <= aNeg_d ^ bNeg_d;
                                negRem_q <= aNeg_d;
                                acc_q    <= '0;
                                mcand_q  <= {{WIDTH{1'b0}}, aMag_d};
                                mplier_q <= bMag_d;
                                cnt_q    <= '0;
                                busy_q   <= 1'b1;
                                state_q  <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (B == '0) begin
                                    quick_q     <= 1'b1;
                                    quickZero_q <= 1'b1;
                                end else begin
                                    isDiv_q  <= 1'b1;
                                    negRes_q <= aNeg_d ^ bNeg_d;
                                    negRem_q <= aNeg_d;
                                    acc_q    <= '0;
                                    mcand_q  <= {{WIDTH{1'b0}}, bMag_d};
                                    mplier_q <= aMag_d;
                                    cnt_q    <= '0;
                                    busy_q   <= 1'b1;
                                    state_q  <= S_RUN;
                                end
                            end
                            OP_MTHI: begin
                                hi_q    <= A;
                                quick_q <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_q    <= A;
                                quick_q <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    if (isDiv_q) begin
                        acc_q    <= {{(WIDTH-1){1'b0}}, remNext_d};
                        mplier_q <= {mplier_q[WIDTH-2:0], qBit_d};
                    end else begin
                        acc_q    <= mulAcc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (lastIter_d) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (isDiv_q) begin
                        hi_q <= rem_d;
                        lo_q <= quo_d;
                    end else begin
                        hi_q <= prod_d[2*WIDTH-1:WIDTH];
                        lo_q <= prod_d[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (WIDTH=32) against an arithmetic model of HI/LO.
module tb_muldiv_unit;
    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             divZero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int passCount  = 0;
    int checkCount = 0;

    logic [31:0] hiModel = '0;
    logic [31:0] loModel = '0;
    logic        zeroModel;
    int          latModel;

    muldiv_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK(clk), .RESET(reset), .start(start), .op(op), .A(a), .B(b),
        .busy(busy), .done(done), .div_zero(divZero), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: updates HI/LO/div_zero expectations and the expected done latency in edges after E0.
    task automatic modelOp(input logic [2:0] mOp, input logic [31:0] mA, input logic [31:0] mB);
        logic [63:0] p;
        longint      sa, sb, q, r;
        logic [31:0] mag;
        int          top;
        zeroModel = 1'b0;
        latModel  = WIDTH + 1;
        case (mOp)
            3'd0: begin
                p = longint'($signed(mA)) * longint'($signed(mB));
                hiModel = p[63:32]; loModel = p[31:0];
            end
            3'd1: begin
                p = {32'b0, mA} * {32'b0, mB};
                hiModel = p[63:32]; loModel = p[31:0];
            end
            3'd2: begin
                if (mB == 0) begin
                    zeroModel = 1'b1; latModel = 1;
                end else begin
                    sa = longint'($signed(mA)); sb = longint'($signed(mB));
                    q = sa / sb; r = sa % sb;
                    loModel = q[31:0]; hiModel = r[31:0];
                end
            end
            3'd3: begin
                if (mB == 0) begin
                    zeroModel = 1'b1; latModel = 1;
                end else begin
                    loModel = mA / mB; hiModel = mA % mB;
                end
            end
            3'd4: begin hiModel = mA; latModel = 1; end
            3'd5: begin loModel = mA; latModel = 1; end
            default: latModel = -1;
        endcase
`ifdef MULDIV_EARLY_OUT_EN
        if (mOp == 3'd0 || mOp == 3'd1) begin
            mag = (mOp == 3'd0 && mB[31]) ? -mB : mB;
            top = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) top = i;
            latModel = top + 2;
        end
`endif
    endtask

    // Issue one request and wait for done; reports latency, busy behaviour and HI/LO stability before done.
    task automatic applyStimulus(input logic [2:0] sOp, input logic [31:0] sA, input logic [31:0] sB,
                                 output int lat, output bit busyOk, output bit holdOk);
        logic [31:0] hiStart, loStart;
        bit expBusy;
        expBusy = (sOp <= 3'd1) || ((sOp == 3'd2 || sOp == 3'd3) && sB != 0);
        @(negedge clk);
        hiStart = hi; loStart = lo;
        start = 1'b1; op = sOp; a = sA; b = sB;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; busyOk = (busy === expBusy); holdOk = 1'b1;
        if (expBusy && (hi !== hiStart || lo !== loStart)) holdOk = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (busy !== expBusy) busyOk = 1'b0;
            if (expBusy && (hi !== hiStart || lo !== loStart)) holdOk = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passCount++;
        checkCount++; if (divZero !== 1'b0) $display("[TB] FAIL reset_divzero: got %b expected 0", divZero); else passCount++;
        checkCount++; if (hi !== 32'h0) $display("[TB] FAIL reset_hi: got %h expected 0", hi); else passCount++;
        checkCount++; if (lo !== 32'h0) $display("[TB] FAIL reset_lo: got %h expected 0", lo); else passCount++;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_multu();
        int lat; bit busyOk, holdOk;
        modelOp(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        applyStimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busyOk, holdOk);
        checkCount++; if (hi !== hiModel) $display("[TB] FAIL multu_hi: got %h expected %h", hi, hiModel); else passCount++;
        checkCount++; if (lo !== loModel) $display("[TB] FAIL multu_lo: got %h expected %h", lo, loModel); else passCount++;
        checkCount++; if (lat !== latModel) $display("[TB] FAIL multu_latency: got %0d expected %0d", lat, latModel); else passCount++;
        checkCount++; if (busyOk !== 1'b1) $display("[TB] FAIL multu_busy_window: got %b expected 1", busyOk); else passCount++;
        checkCount++; if (holdOk !== 1'b1) $display("[TB] FAIL multu_hilo_hold: got %b expected 1", holdOk); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL multu_busy_in_done: got %b expected 0", busy); else passCount++;
        @(posedge clk); #1;
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL multu_done_pulse: got %b expected 0", done); else passCount++;
        checkCount++; if (divZero !== 1'b0) $display("[TB] FAIL multu_divzero_idle: got %b expected 0", divZero); else passCount++;
    endtask

    task automatic test_signed();
        int lat; bit busyOk, holdOk;
        logic [2:0]  tOp [3] = '{3'd0, 3'd2, 3'd2};
        logic [31:0] tA  [3] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'h80000000};
        logic [31:0] tB  [3] = '{32'd5, 32'd2, 32'hFFFFFFFF};
        for (int i = 0; i < 3; i++) begin
            modelOp(tOp[i], tA[i], tB[i]);
            applyStimulus(tOp[i], tA[i], tB[i], lat, busyOk, holdOk);
            checkCount++; if (hi !== hiModel) $display("[TB] FAIL signed%0d_hi: got %h expected %h", i, hi, hiModel); else passCount++;
            checkCount++; if (lo !== loModel) $display("[TB] FAIL signed%0d_lo: got %h expected %h", i, lo, loModel); else passCount++;
            checkCount++; if (divZero !== 1'b0) $display("[TB] FAIL signed%0d_divzero: got %b expected 0", i, divZero); else passCount++;
        end
    endtask

    task automatic test_div_zero();
        int lat; bit busyOk, holdOk;
        modelOp(3'd4, 32'h11, 32'h0);
        applyStimulus(3'd4, 32'h11, 32'h0, lat, busyOk, holdOk);
        checkCount++; if (lat !== latModel) $display("[TB] FAIL mthi_latency: got %0d expected %0d", lat, latModel); else passCount++;
        checkCount++; if (busyOk !== 1'b1) $display("[TB] FAIL mthi_busy: got %b expected 1", busyOk); else passCount++;
        modelOp(3'd5, 32'h22, 32'h0);
        applyStimulus(3'd5, 32'h22, 32'h0, lat, busyOk, holdOk);
        checkCount++; if (lo !== loModel) $display("[TB] FAIL mtlo_lo: got %h expected %h", lo, loModel); else passCount++;
        modelOp(3'd3, 32'd100, 32'd0);
        applyStimulus(3'd3, 32'd100, 32'd0, lat, busyOk, holdOk);
        checkCount++; if (lat !== latModel) $display("[TB] FAIL divzero_latency: got %0d expected %0d", lat, latModel); else passCount++;
        checkCount++; if (divZero !== zeroModel) $display("[TB] FAIL divzero_flag: got %b expected %b", divZero, zeroModel); else passCount++;
        checkCount++; if (busyOk !== 1'b1) $display("[TB] FAIL divzero_busy: got %b expected 1", busyOk); else passCount++;
        checkCount++; if (hi !== hiModel) $display("[TB] FAIL divzero_hi: got %h expected %h", hi, hiModel); else passCount++;
        checkCount++; if (lo !== loModel) $display("[TB] FAIL divzero_lo: got %h expected %h", lo, loModel); else passCount++;
    endtask

    task automatic test_busy_ignore();
        int lat; bit doneSeen;
        modelOp(3'd3, 32'd100, 32'd7);
        @(negedge clk); start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            if (i == 10) begin
                @(negedge clk); start = 1'b1; op = 3'd5; a = 32'd5;
            end
            @(posedge clk); #1; start = 1'b0;
            if (done === 1'b1) begin lat = i; break; end
        end
        checkCount++; if (lat !== latModel) $display("[TB] FAIL ignore_latency: got %0d expected %0d", lat, latModel); else passCount++;
        checkCount++; if (lo !== loModel) $display("[TB] FAIL ignore_lo: got %h expected %h", lo, loModel); else passCount++;
        checkCount++; if (hi !== hiModel) $display("[TB] FAIL ignore_hi: got %h expected %h", hi, hiModel); else passCount++;
        doneSeen = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (done === 1'b1) doneSeen = 1'b1; end
        checkCount++; if (doneSeen !== 1'b0) $display("[TB] FAIL ignore_no_extra_done: got %b expected 0", doneSeen); else passCount++;
        checkCount++; if (lo !== loModel) $display("[TB] FAIL ignore_lo_kept: got %h expected %h", lo, loModel); else passCount++;
    endtask

    task automatic test_reset_abort();
        int lat; bit busyOk, holdOk, doneSeen;
        modelOp(3'd4, 32'hAAAA, 32'h0);
        applyStimulus(3'd4, 32'hAAAA, 32'h0, lat, busyOk, holdOk);
        @(negedge clk); start = 1'b1; op = 3'd1; a = 32'hDEADBEEF; b = 32'h1234;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        hiModel = '0; loModel = '0;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy); else passCount++;
        checkCount++; if (hi !== hiModel) $display("[TB] FAIL abort_hi: got %h expected %h", hi, hiModel); else passCount++;
        checkCount++; if (lo !== loModel) $display("[TB] FAIL abort_lo: got %h expected %h", lo, loModel); else passCount++;
        @(negedge clk); reset = 1'b0;
        doneSeen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1) doneSeen = 1'b1; end
        checkCount++; if (doneSeen !== 1'b0) $display("[TB] FAIL abort_no_done: got %b expected 0", doneSeen); else passCount++;
        modelOp(3'd1, 32'd6, 32'd7);
        applyStimulus(3'd1, 32'd6, 32'd7, lat, busyOk, holdOk);
        checkCount++; if (lo !== loModel) $display("[TB] FAIL abort_fresh_lo: got %h expected %h", lo, loModel); else passCount++;
        checkCount++; if (lat !== latModel) $display("[TB] FAIL abort_fresh_latency: got %0d expected %0d", lat, latModel); else passCount++;
    endtask

    task automatic test_reserved();
        bit doneSeen, busySeen;
        doneSeen = 1'b0; busySeen = 1'b0;
        @(negedge clk); start = 1'b1; op = 3'd6; a = 32'h1; b = 32'h1;
        @(negedge clk); op = 3'd7;
        @(negedge clk); start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done === 1'b1) doneSeen = 1'b1;
            if (busy === 1'b1) busySeen = 1'b1;
        end
        checkCount++; if (doneSeen !== 1'b0) $display("[TB] FAIL reserved_done: got %b expected 0", doneSeen); else passCount++;
        checkCount++; if (busySeen !== 1'b0) $display("[TB] FAIL reserved_busy: got %b expected 0", busySeen); else passCount++;
        checkCount++; if (hi !== hiModel || lo !== loModel) $display("[TB] FAIL reserved_hilo: got %h/%h expected %h/%h", hi, lo, hiModel, loModel); else passCount++;
    endtask

    task automatic test_back_to_back();
        int lat; bit busyOk, holdOk;
        modelOp(3'd2, 32'd1000, 32'hFFFFFFF9);
        applyStimulus(3'd2, 32'd1000, 32'hFFFFFFF9, lat, busyOk, holdOk);
        checkCount++; if (lo !== loModel || hi !== hiModel) $display("[TB] FAIL b2b_div: got %h/%h expected %h/%h", hi, lo, hiModel, loModel); else passCount++;
        modelOp(3'd5, 32'h5A5A, 32'h0);
        applyStimulus(3'd5, 32'h5A5A, 32'h0, lat, busyOk, holdOk);
        checkCount++; if (lat !== latModel) $display("[TB] FAIL b2b_latency: got %0d expected %0d", lat, latModel); else passCount++;
        checkCount++; if (lo !== loModel) $display("[TB] FAIL b2b_lo: got %h expected %h", lo, loModel); else passCount++;
    endtask

    task automatic test_random();
        int lat; bit busyOk, holdOk;
        logic [2:0]  rOp;
        logic [31:0] rA, rB;
        for (int i = 0; i < 24; i++) begin
            rOp = 3'($urandom_range(0, 5));
            rA  = $urandom;
            rB  = $urandom;
            case ($urandom_range(0, 5))
                0: rB = 32'h0;
                1: rB = 32'hFFFFFFFF;
                2: rB = 32'($urandom_range(1, 300));
                3: rA = 32'h80000000;
                default: ;
            endcase
            modelOp(rOp, rA, rB);
            applyStimulus(rOp, rA, rB, lat, busyOk, holdOk);
            checkCount++; if (hi !== hiModel) $display("[TB] FAIL rand%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, rOp, rA, rB, hi, hiModel); else passCount++;
            checkCount++; if (lo !== loModel) $display("[TB] FAIL rand%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, rOp, rA, rB, lo, loModel); else passCount++;
            checkCount++; if (divZero !== zeroModel) $display("[TB] FAIL rand%0d_divzero: got %b expected %b", i, divZero, zeroModel); else passCount++;
            checkCount++; if (lat !== latModel) $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", i, lat, latModel); else passCount++;
        end
    endtask

`ifdef MULDIV_EARLY_OUT_EN
    task automatic test_early_out();
        int lat; bit busyOk, holdOk;
        modelOp(3'd1, 32'h12345678, 32'd3);
        applyStimulus(3'd1, 32'h12345678, 32'd3, lat, busyOk, holdOk);
        checkCount++; if (lo !== loModel) $display("[TB] FAIL early_lo: got %h expected %h", lo, loModel); else passCount++;
        checkCount++; if (hi !== hiModel) $display("[TB] FAIL early_hi: got %h expected %h", hi, hiModel); else passCount++;
        checkCount++; if (lat !== latModel) $display("[TB] FAIL early_latency: got %0d expected %0d", lat, latModel); else passCount++;
    endtask
`endif

    initial begin
        $display("[TB] muldiv_unit bench start");
        test_reset();
        test_multu();
        test_signed();
        test_div_zero();
        test_busy_ignore();
        test_reset_abort();
        test_reserved();
        test_back_to_back();
        test_random();
`ifdef MULDIV_EARLY_OUT_EN
        test_early_out();
`endif
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit with architectural HI/LO registers, parametrised in datapath width. It replaces the single-cycle HI/LO path of the CPU ALU: the decoder issues mult/multu/div/divu/mthi/mtlo here through a start/busy/done handshake, and mfhi/mflo read `HI`/`LO` directly. Signed operations, divide-by-zero detection and a defined overflow result are part of this block; the old path did not provide them.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; must be ≥ 4.
- `CNT_W`, `$clog2(WIDTH+1)`, iteration counter width.

Ports:
- `CLK`  in  1  rising-edge clock
- `RESET`  in  1  synchronous, active-high reset
- `start`  in  1  issue request; sampled only when `busy`=0
- `op`  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved
- `A`  in  WIDTH  operand rs (dividend / multiplicand / mthi, mtlo source)
- `B`  in  WIDTH  operand rt (divisor / multiplier)
- `busy`  out  1  operation in flight; new `start` is ignored
- `done`  out  1  one-cycle pulse when HI/LO have been updated
- `div_zero`  out  1  valid with `done`; 1 if the divide had `B`=0
- `HI`  out  WIDTH  high product / remainder
- `LO`  out  WIDTH  low product / quotient

## Operation
- States: IDLE, RUN, FIX.
- IDLE plus `start` with mult/multu/div/divu: latch `op`. Signed ops latch |A| and |B| plus the result-sign flags. Clear the accumulator and set count=0, then go to RUN.
- RUN, multiply: radix-2 shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- RUN, divide: restoring division, one quotient bit per cycle; the partial remainder is WIDTH+1 bits wide.
- RUN ends after exactly WIDTH iterations (count = WIDTH−1 on the last one), then go to FIX.
- FIX:
  - Apply the sign corrections.
  - Mult: two's-complement negate the 2·WIDTH product if the signs differ.
  - Div: quotient negated if the signs differ, truncating toward zero. Remainder takes the sign of the dividend.
  - Write HI/LO, pulse `done`, go to IDLE.
- Signed overflow (A = min, B = −1): LO = min, HI = 0 (natural WIDTH-bit wrap). No flag.
- Divide with `B`=0:
  - No iteration; HI/LO are unchanged.
  - Next cycle `done`=1 and `div_zero`=1; `busy` is never asserted.
- mthi/mtlo: HI (resp. LO) ← A at the sampling edge. `done` pulses next cycle; `busy` is never asserted.
- Reserved `op` is ignored: no `done`, no state change.
- `start` while `busy`=1 is ignored and not queued.
- `HI`/`LO` hold their previous values until the FIX write; there are no intermediate values on the outputs.

## Timing
- Reset values: `busy`=0, `done`=0, `div_zero`=0, `HI`=0, `LO`=0, state IDLE, count 0.
- Edge E0 samples `start`:
  - `busy`=1 from E0 through E(WIDTH+1).
  - HI/LO written at E(WIDTH+1).
  - `done`=1 for the single cycle after E(WIDTH+1), with `busy`=0 in that same cycle.
- Total latency for mult/div with `B`≠0 is WIDTH+1 edges (33 for WIDTH=32).
- Latency for mthi/mtlo and divide-by-zero is 1 edge.
- `start` in the `done` cycle is accepted, giving back-to-back issue with no bubble.
- `RESET` mid-operation aborts the operation: all outputs return to reset values at that edge, and `done` is not produced.
- `div_zero` is 0 whenever `done` is 0.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined:
  - For multu/mult, when the remaining (shifted) multiplier bits are all zero, RUN exits to FIX immediately.
  - Latency becomes (index of the highest set magnitude bit of B)+2 edges, minimum 2.
  - The result is bit-identical to the non-early-out result.
- Not defined: every mult/div takes the fixed WIDTH+1 edges. No early-out comparator is synthesised.

## Test plan
- WIDTH=32, multu A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001, `done` 33 edges after start (macro undefined).
- mult A=−3 (0xFFFFFFFD), B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- div A=−7, B=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0, `div_zero`=0.
- divu A=100, B=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo → `done`+`div_zero` next cycle, HI=0x11, LO=0x22, `busy` stays 0.
- divu A=100, B=7 and a second `start` (mtlo A=5) at cycle 10 → second request ignored, LO=14, HI=2. `RESET` asserted at cycle 10 of a further multu → HI=LO=0, `busy`=0, no `done`; a fresh multu 6×7 then gives LO=42.
- `MULDIV_EARLY_OUT_EN` defined: multu A=0x12345678, B=3 → LO=0x369D0368, HI=0, `done` 3 edges after start.
